// File: rtl/spi_pkg.sv
// spi_pkg: shared state, mode and default-width definitions for the SPI clock generator
package spi_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 6;
  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;
endpackage

// File: rtl/spi_sclk_gen_if.sv
// spi_sclk_gen_if: control inputs and clock/strobe outputs of the SPI clock generator
interface spi_sclk_gen_if #(
  parameter int DIV_W = spi_pkg::DIV_W_DEF,
  parameter int CNT_W = spi_pkg::CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             cpol;
  logic             cpha;
  logic             sclk;
  logic             sample_stb;
  logic             shift_stb;
  logic             busy;
  logic             done;
  modport master (
    output start, abort, div, nbits, cpol, cpha,
    input  sclk, sample_stb, shift_stb, busy, done
  );
  modport slave (
    input  start, abort, div, nbits, cpol, cpha,
    output sclk, sample_stb, shift_stb, busy, done
  );
endinterface

// File: rtl/spi_half_cnt.sv
// spi_half_cnt: saturating half-period down-counter with reload and zero flag
module spi_half_cnt #(
  parameter int DIV_W = spi_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] value,
  output logic             zero
);
  logic [DIV_W-1:0] cnt;
  // load has priority; decrement stops at zero so the counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - DIV_W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial clock generator with mode-dependent sample/shift strobes
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  spi_sclk_gen_if.slave bus
);
  state_t           state;
  spi_mode_t        mode_l;
  logic [DIV_W-1:0] div_l;
  logic [CNT_W-1:0] nbits_l;
  logic [CNT_W:0]   edge_cnt;
  logic [CNT_W:0]   edge_nxt;
  logic             zero;
  logic             accept;
  logic             last;
  logic             lead;
  logic             cpol_l;
  logic             cpha_l;
  // acceptance, next-edge classification and latched mode bits
  always_comb begin
    accept   = state == IDLE && bus.start && !bus.abort;
    edge_nxt = edge_cnt + (CNT_W+1)'(1);
    last     = edge_nxt == {nbits_l, 1'b0};
    lead     = !edge_cnt[0];
    cpol_l   = mode_l[MODE_CPOL];
    cpha_l   = mode_l[MODE_CPHA];
  end
  spi_half_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept || (state != IDLE && zero)),
    .en    (state != IDLE),
    .value (accept ? bus.div : div_l),
    .zero  (zero)
  );
  // burst FSM with registered clock, strobes and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_l         <= MODE0;
      div_l          <= '0;
      nbits_l        <= '0;
      edge_cnt       <= '0;
      bus.sclk       <= 1'b0;
      bus.sample_stb <= 1'b0;
      bus.shift_stb  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.sample_stb <= 1'b0;
      bus.shift_stb  <= 1'b0;
      bus.done       <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state    <= IDLE;
        bus.sclk <= cpol_l;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.sclk <= bus.cpol;
            if (accept) begin
              state    <= bus.nbits == '0 ? TAIL : RUN;
              bus.busy <= 1'b1;
              div_l    <= bus.div;
              nbits_l  <= bus.nbits;
              mode_l   <= spi_mode_t'({bus.cpol, bus.cpha});
              edge_cnt <= '0;
            end
          end
          RUN: begin
            if (zero) begin
              bus.sclk       <= !bus.sclk;
              edge_cnt       <= edge_nxt;
              bus.sample_stb <= cpha_l ? !lead : lead;
              bus.shift_stb  <= cpha_l ? lead : !lead && !last;
              if (last) state <= TAIL;
            end
          end
          TAIL: begin
            if (zero) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed bursts with hand-computed edge, strobe and timing expectations
module tb_spi_sclk_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_sclk_gen_if bus ();
  spi_sclk_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0;
  int n_fail = 0;
  int acc, acc_busy, n_edge, n_rise, n_samp, n_samp_rise, n_shift, n_shift_fall, n_mis, n_done;
  int first_off, last_off, done_off, gap_min, gap_max, ab_busy, ab_sclk, end_sclk, tail;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic burst(input int d, input int n, input logic pol, input logic pha,
                       input int ab_e, input int st_e);
    logic prev;
    logic chg;
    int   last_c;
    int   ab_c;
    int   g;
    @(negedge clk);
    bus.div = d[7:0]; bus.nbits = n[5:0]; bus.cpol = pol; bus.cpha = pha;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc = cyc; acc_busy = bus.busy; prev = bus.sclk;
    n_edge = 0; n_rise = 0; n_samp = 0; n_samp_rise = 0; n_shift = 0; n_shift_fall = 0;
    n_mis = 0; n_done = 0; first_off = -1; done_off = -1; gap_min = 1000; gap_max = 0;
    ab_busy = -1; ab_sclk = -1; last_c = acc; ab_c = -1; tail = -1;
    for (int i = 0; i < 300 && tail != 0; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chg = bus.sclk !== prev;
      prev = bus.sclk;
      if (chg) begin
        n_edge++;
        if (bus.sclk) n_rise++;
        if (first_off < 0) first_off = cyc - acc;
        else begin
          g = cyc - last_c;
          gap_min = g < gap_min ? g : gap_min;
          gap_max = g > gap_max ? g : gap_max;
        end
        last_c = cyc;
      end
      if (bus.sample_stb) begin
        n_samp++;
        if (chg && bus.sclk) n_samp_rise++;
        if (!chg) n_mis++;
      end
      if (bus.shift_stb) begin
        n_shift++;
        if (chg && !bus.sclk) n_shift_fall++;
        if (!chg) n_mis++;
      end
      if (bus.done) begin
        n_done++;
        done_off = cyc - acc;
      end
      if (ab_c >= 0 && cyc == ab_c + 1) begin
        ab_busy = bus.busy;
        ab_sclk = bus.sclk;
      end
      if (chg && n_edge == ab_e) begin
        bus.abort = 1'b1;
        ab_c = cyc;
      end
      if (chg && n_edge == st_e) begin
        bus.start = 1'b1; bus.nbits = 6'd2; bus.div = 8'd0;
      end
      if (tail > 0) tail--;
      else if (tail < 0 && !bus.busy) tail = 4;
    end
    end_sclk = bus.sclk;
    last_off = last_c - acc;
    check("terminated", tail, 0);
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.div = '0; bus.nbits = '0;
    bus.cpol = 1'b0; bus.cpha = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {bus.sclk, bus.sample_stb, bus.shift_stb, bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.cpol = 1'b1;
    @(negedge clk);
    check("idle_cpol_hi", bus.sclk, 1);
    bus.cpol = 1'b0;
    @(negedge clk);
    check("idle_cpol_lo", bus.sclk, 0);
    burst(1, 8, 1'b0, 1'b0, 0, 0);
    check("m0_busy", acc_busy, 1);
    check("m0_edges", n_edge, 16);
    check("m0_rises", n_rise, 8);
    check("m0_samp", n_samp, 8);
    check("m0_samp_rise", n_samp_rise, 8);
    check("m0_shift", n_shift, 7);
    check("m0_shift_fall", n_shift_fall, 7);
    check("m0_misaligned", n_mis, 0);
    check("m0_first", first_off, 2);
    check("m0_gap_min", gap_min, 2);
    check("m0_gap_max", gap_max, 2);
    check("m0_last", last_off, 32);
    check("m0_done_at", done_off, 34);
    check("m0_done_cnt", n_done, 1);
    check("m0_end_sclk", end_sclk, 0);
    burst(0, 4, 1'b1, 1'b1, 0, 0);
    check("m3_edges", n_edge, 8);
    check("m3_rises", n_rise, 4);
    check("m3_shift_fall", n_shift_fall, 4);
    check("m3_shift", n_shift, 4);
    check("m3_samp_rise", n_samp_rise, 4);
    check("m3_samp", n_samp, 4);
    check("m3_misaligned", n_mis, 0);
    check("m3_first", first_off, 1);
    check("m3_gap_max", gap_max, 1);
    check("m3_done_at", done_off, 9);
    check("m3_end_sclk", end_sclk, 1);
    burst(1, 8, 1'b0, 1'b0, 5, 0);
    check("ab_busy", ab_busy, 0);
    check("ab_sclk", ab_sclk, 0);
    check("ab_done", n_done, 0);
    check("ab_samp", n_samp, 3);
    check("ab_shift", n_shift, 2);
    check("ab_edges", n_edge, 6);
    burst(1, 8, 1'b0, 1'b0, 0, 3);
    check("sb_edges", n_edge, 16);
    check("sb_last", last_off, 32);
    check("sb_gap_min", gap_min, 2);
    check("sb_done_cnt", n_done, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.nbits = 6'd4; bus.div = 8'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("sa_busy0", bus.busy, 0);
    @(negedge clk);
    check("sa_busy1", bus.busy, 0);
    burst(3, 0, 1'b0, 1'b0, 0, 0);
    check("z_edges", n_edge, 0);
    check("z_strobes", n_samp + n_shift, 0);
    check("z_done_at", done_off, 4);
    check("z_done_cnt", n_done, 1);
    @(negedge clk);
    bus.div = 8'd0; bus.nbits = 6'd8; bus.cpol = 1'b0; bus.cpha = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst", {bus.sclk, bus.sample_stb, bus.shift_stb, bus.busy, bus.done}, 5'b11010);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {bus.sclk, bus.sample_stb, bus.shift_stb, bus.busy, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    burst(0, 2, 1'b0, 1'b0, 0, 0);
    check("post_rst_edges", n_edge, 4);
    check("post_rst_done", n_done, 1);
    check("post_rst_done_at", done_off, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
